alu_op_decoder: RTL and testbench
=================================

Name: alu_op_decoder

Overview:
- Registered ALU-control decoder for the 19-bit CPU. Sits between the instruction decode stage and the ALU.
- Maps the 5-bit primary opcode and the 5-bit function field to a 5-bit ALU operation code.
- Flags encodings it does not recognise.
- Output is registered: one cycle of latency, synchronous active-low reset.

Parameters:
- OP_W, 5, width of opcode, funct and operation.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- opcode  input  5  primary instruction opcode.
- funct  input  5  function field; used only by opcodes 0 and 1.
- operation  output  5  ALU operation code, registered.
- illegal  output  1  registered flag; 1 = unrecognised opcode/funct combination.

Behaviour:
- Reset: on a rising edge with rst_n=0, operation=0 (ADD) and illegal=0. Reset has priority over any decode.
- Latency: the inputs sampled at edge N appear on the outputs after edge N. There is no handshake; a new decode occurs every cycle.
- ALU operation codes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR
  - 8 NOT, 9 SLL, 10 SRL, 11 SRA, 12 ROL, 13 ROR, 14 SLT, 15 SLTU
  - 16 INC, 17 DEC, 18 NEG, 19 PASSA, 20 PASSB, 21 CMP, 22 NAND, 23 NOR
  - 24-31 are reserved and never produced.
- Opcode 0 (R-type base):
  - funct 0-15: operation = funct.
  - funct 16-31: illegal.
- Opcode 1 (R-type extended):
  - funct 0-7: operation = 16 + funct.
  - funct 8-31: illegal.
- Immediate/memory/branch opcodes (funct ignored):
  - 2 ADDI->ADD, 3 SUBI->SUB, 4 ANDI->AND, 5 ORI->OR, 6 XORI->XOR
  - 7 SLLI->SLL, 8 SRLI->SRL
  - 9 LD->ADD, 10 ST->ADD (address computation)
  - 11 BEQ->SUB, 12 BNE->SUB, 13 BLT->SLT
  - 14 JMP->PASSB, 15 JAL->PASSB, 16 LUI->PASSB
- Opcodes 17-31: illegal.
- Illegal case: operation=0 (ADD) and illegal=1. A safe default, never X.
- Illegal is combinationally derived from the same sampled inputs and is registered alongside operation; the two are always coherent in the same cycle.
- X/Z on the inputs does not need defined handling, but the decode uses a full case with a default, so no latches are inferred.
- A reset assertion mid-stream overrides the decode at that edge. The first edge after rst_n rises decodes normally.

Decomposition:
- Shared package cpu19_pkg holds:
  - ALU operation enum (alu_op_t, 5 bits, values above)
  - opcode localparams (OPC_RTYPE=0, OPC_REXT=1, ... OPC_LUI=16)
  - funct width constant
  The ALU imports the same enum.
- One natural sub-module: alu_op_decode_comb, a pure combinational opcode/funct -> {operation, illegal} table. The top module registers its outputs with the synchronous reset.

Test Plan:
- Reset: rst_n=0 for 2 edges with opcode=5, funct=3 -> operation=0, illegal=0. After release with the same inputs, the next edge gives operation=6 (OR), illegal=0.
- R-type sweep:
  - opcode=0, funct=0..15 -> operation=funct, illegal=0 (e.g. funct=0 -> 0 ADD).
  - funct=16 and funct=31 -> operation=0, illegal=1.
- Extended: opcode=1, funct=4 -> operation=20 (PASSB); funct=7 -> 23 (NOR); funct=8 -> operation=0, illegal=1.
- Immediate, funct ignored:
  - opcode=2, funct=0 -> 0 (ADD); opcode=2, funct=31 -> 0.
  - opcode=13 -> 14 (SLT); opcode=16 -> 20.
  - All with illegal=0.
- Illegal opcodes: opcode=17..31 with random funct -> operation=0, illegal=1 each cycle.
- Latency and back-to-back:
  - Inputs change every cycle (0/0, 1/4, 2/0); outputs follow one edge later as 0, 20, 0 with illegal=0.
  - rst_n pulsed low for one edge mid-sequence -> that cycle's outputs are 0/0, and the next edge resumes the correct decode.

Source files
------------

// File: rtl/cpu19_pkg.sv
// rtl/cpu19_pkg.sv - shared CPU19 types: ALU operation enum, opcode map, field widths
//
// Purpose : single source of truth for the ALU operation encoding and the
//           primary opcode map. Shared by the ALU control decoder and the ALU.
// Contents: ALU_OP_W, OPCODE_W, FUNCT_W  - field widths
//           alu_op_t                     - 5-bit ALU operation code (24..31 reserved)
//           OPC_*                        - primary opcode values
//           RTYPE_FUNCT_LIMIT, REXT_FUNCT_LIMIT - first illegal funct for opcodes 0/1
package cpu19_pkg;

    localparam int ALU_OP_W = 5;
    localparam int OPCODE_W = 5;
    localparam int FUNCT_W  = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_MUL   = 5'd2,
        ALU_DIV   = 5'd3,
        ALU_MOD   = 5'd4,
        ALU_AND   = 5'd5,
        ALU_OR    = 5'd6,
        ALU_XOR   = 5'd7,
        ALU_NOT   = 5'd8,
        ALU_SLL   = 5'd9,
        ALU_SRL   = 5'd10,
        ALU_SRA   = 5'd11,
        ALU_ROL   = 5'd12,
        ALU_ROR   = 5'd13,
        ALU_SLT   = 5'd14,
        ALU_SLTU  = 5'd15,
        ALU_INC   = 5'd16,
        ALU_DEC   = 5'd17,
        ALU_NEG   = 5'd18,
        ALU_PASSA = 5'd19,
        ALU_PASSB = 5'd20,
        ALU_CMP   = 5'd21,
        ALU_NAND  = 5'd22,
        ALU_NOR   = 5'd23
    } alu_op_t;

    localparam logic [OPCODE_W-1:0] OPC_RTYPE = 5'd0;
    localparam logic [OPCODE_W-1:0] OPC_REXT  = 5'd1;
    localparam logic [OPCODE_W-1:0] OPC_ADDI  = 5'd2;
    localparam logic [OPCODE_W-1:0] OPC_SUBI  = 5'd3;
    localparam logic [OPCODE_W-1:0] OPC_ANDI  = 5'd4;
    localparam logic [OPCODE_W-1:0] OPC_ORI   = 5'd5;
    localparam logic [OPCODE_W-1:0] OPC_XORI  = 5'd6;
    localparam logic [OPCODE_W-1:0] OPC_SLLI  = 5'd7;
    localparam logic [OPCODE_W-1:0] OPC_SRLI  = 5'd8;
    localparam logic [OPCODE_W-1:0] OPC_LD    = 5'd9;
    localparam logic [OPCODE_W-1:0] OPC_ST    = 5'd10;
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = 5'd11;
    localparam logic [OPCODE_W-1:0] OPC_BNE   = 5'd12;
    localparam logic [OPCODE_W-1:0] OPC_BLT   = 5'd13;
    localparam logic [OPCODE_W-1:0] OPC_JMP   = 5'd14;
    localparam logic [OPCODE_W-1:0] OPC_JAL   = 5'd15;
    localparam logic [OPCODE_W-1:0] OPC_LUI   = 5'd16;

    // R-type base maps funct 0..15 straight onto ALU_ADD..ALU_SLTU;
    // R-type extended maps funct 0..7 onto ALU_INC..ALU_NOR.
    localparam logic [FUNCT_W-1:0] RTYPE_FUNCT_LIMIT = 5'd16;
    localparam logic [FUNCT_W-1:0] REXT_FUNCT_LIMIT  = 5'd8;

endpackage

// File: rtl/alu_op_decode_comb.sv
// rtl/alu_op_decode_comb.sv - combinational opcode/funct to ALU operation table
//
// Purpose : pure lookup from {opcode, funct} to {ALU operation, illegal}.
//           Unrecognised encodings produce ALU_ADD with illegal set, so the
//           ALU never sees a reserved operation code.
// Ports   : i_opcode    - primary opcode
//           i_funct     - function field, only consulted for opcodes 0 and 1
//           o_operation - ALU operation code
//           o_illegal   - 1 when the combination is not recognised
module alu_op_decode_comb
    import cpu19_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0] i_opcode,
    input  logic [OP_W-1:0] i_funct,
    output logic [OP_W-1:0] o_operation,
    output logic            o_illegal
);

    alu_op_t w_alu_op;

    always_comb begin
        w_alu_op  = ALU_ADD;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_RTYPE: begin
                if (i_funct < RTYPE_FUNCT_LIMIT) begin
                    w_alu_op = alu_op_t'(i_funct);
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OPC_REXT: begin
                // Extended ops sit at ALU_INC + funct; the sum stays below 24.
                if (i_funct < REXT_FUNCT_LIMIT) begin
                    w_alu_op = alu_op_t'(ALU_INC + i_funct);
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OPC_ADDI: w_alu_op = ALU_ADD;
            OPC_SUBI: w_alu_op = ALU_SUB;
            OPC_ANDI: w_alu_op = ALU_AND;
            OPC_ORI:  w_alu_op = ALU_OR;
            OPC_XORI: w_alu_op = ALU_XOR;
            OPC_SLLI: w_alu_op = ALU_SLL;
            OPC_SRLI: w_alu_op = ALU_SRL;
            // Loads and stores use the ALU for base + offset.
            OPC_LD:   w_alu_op = ALU_ADD;
            OPC_ST:   w_alu_op = ALU_ADD;
            // Branches compare operands; the branch unit reads the result flags.
            OPC_BEQ:  w_alu_op = ALU_SUB;
            OPC_BNE:  w_alu_op = ALU_SUB;
            OPC_BLT:  w_alu_op = ALU_SLT;
            // Jumps and LUI forward the immediate/target operand unchanged.
            OPC_JMP:  w_alu_op = ALU_PASSB;
            OPC_JAL:  w_alu_op = ALU_PASSB;
            OPC_LUI:  w_alu_op = ALU_PASSB;
            default: begin
                w_alu_op  = ALU_ADD;
                o_illegal = 1'b1;
            end
        endcase
    end

    assign o_operation = w_alu_op;

endmodule

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - registered ALU-control decoder between decode and ALU
//
// Purpose : decodes opcode/funct every cycle and registers the ALU operation
//           together with its illegal flag; one cycle of latency, no handshake.
// Ports   : clk       - system clock, rising edge
//           rst_n     - synchronous active-low reset (outputs -> ADD, legal)
//           opcode    - primary instruction opcode
//           funct     - function field (opcodes 0 and 1 only)
//           operation - registered ALU operation code
//           illegal   - registered flag, 1 = unrecognised opcode/funct
module alu_op_decoder
    import cpu19_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    output logic [OP_W-1:0] operation,
    output logic            illegal
);

    logic [OP_W-1:0] w_operation;
    logic            w_illegal;
    logic [OP_W-1:0] r_operation;
    logic            r_illegal;

    alu_op_decode_comb #(
        .OP_W (OP_W)
    ) u_decode (
        .i_opcode    (opcode),
        .i_funct     (funct),
        .o_operation (w_operation),
        .o_illegal   (w_illegal)
    );

    // Operation and illegal are captured on the same edge so they always
    // describe the same instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_operation <= OP_W'(ALU_ADD);
            r_illegal   <= 1'b0;
        end else begin
            r_operation <= w_operation;
            r_illegal   <= w_illegal;
        end
    end

    assign operation = r_operation;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb/tb_alu_op_decoder.sv - scoreboard bench for alu_op_decoder
module tb_alu_op_decoder;

    typedef struct {
        logic [4:0] op;
        logic       ill;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] opcode;
    logic [4:0] funct;
    logic [4:0] operation;
    logic       illegal;

    exp_t sb[$];
    int   n_pass;
    int   n_total;

    alu_op_decoder #(
        .OP_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct     (funct),
        .operation (operation),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge and the expected response is queued
    // with them; the rising edge that follows captures that vector.
    task automatic drive(input logic rst, input logic [4:0] op, input logic [4:0] fn,
                         input logic [4:0] exp_op, input logic exp_ill, input string name);
        exp_t e;
        @(negedge clk);
        rst_n  = rst;
        opcode = op;
        funct  = fn;
        e.op   = exp_op;
        e.ill  = exp_ill;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: every rising edge presents a new decode; check it 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_total++;
                if (operation === e.op && illegal === e.ill) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got operation=%0d illegal=%b, expected operation=%0d illegal=%b",
                             e.name, operation, illegal, e.op, e.ill);
                end
            end
        end
    end

    initial begin
        logic [4:0] rf;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        opcode  = 5'd5;
        funct   = 5'd3;

        // Reset held for two edges, then released with the same ORI inputs.
        drive(1'b0, 5'd5, 5'd3, 5'd0, 1'b0, "reset_edge0");
        drive(1'b0, 5'd5, 5'd3, 5'd0, 1'b0, "reset_edge1");
        drive(1'b1, 5'd5, 5'd3, 5'd6, 1'b0, "ori_after_reset");

        // R-type base: funct 0..15 passes straight through.
        for (int f = 0; f < 16; f++) begin
            drive(1'b1, 5'd0, 5'(f), 5'(f), 1'b0, $sformatf("rtype_f%0d", f));
        end
        drive(1'b1, 5'd0, 5'd16, 5'd0, 1'b1, "rtype_f16_illegal");
        drive(1'b1, 5'd0, 5'd31, 5'd0, 1'b1, "rtype_f31_illegal");

        // R-type extended.
        drive(1'b1, 5'd1, 5'd0, 5'd16, 1'b0, "rext_f0_inc");
        drive(1'b1, 5'd1, 5'd4, 5'd20, 1'b0, "rext_f4_passb");
        drive(1'b1, 5'd1, 5'd7, 5'd23, 1'b0, "rext_f7_nor");
        drive(1'b1, 5'd1, 5'd8, 5'd0,  1'b1, "rext_f8_illegal");
        drive(1'b1, 5'd1, 5'd31, 5'd0, 1'b1, "rext_f31_illegal");

        // Immediate / memory / branch opcodes, funct ignored.
        drive(1'b1, 5'd2,  5'd0,  5'd0,  1'b0, "addi_f0");
        drive(1'b1, 5'd2,  5'd31, 5'd0,  1'b0, "addi_f31");
        drive(1'b1, 5'd3,  5'd9,  5'd1,  1'b0, "subi");
        drive(1'b1, 5'd4,  5'd17, 5'd5,  1'b0, "andi");
        drive(1'b1, 5'd6,  5'd2,  5'd7,  1'b0, "xori");
        drive(1'b1, 5'd7,  5'd30, 5'd9,  1'b0, "slli");
        drive(1'b1, 5'd8,  5'd1,  5'd10, 1'b0, "srli");
        drive(1'b1, 5'd9,  5'd20, 5'd0,  1'b0, "ld");
        drive(1'b1, 5'd10, 5'd11, 5'd0,  1'b0, "st");
        drive(1'b1, 5'd11, 5'd5,  5'd1,  1'b0, "beq");
        drive(1'b1, 5'd12, 5'd6,  5'd1,  1'b0, "bne");
        drive(1'b1, 5'd13, 5'd0,  5'd14, 1'b0, "blt");
        drive(1'b1, 5'd14, 5'd3,  5'd20, 1'b0, "jmp");
        drive(1'b1, 5'd15, 5'd25, 5'd20, 1'b0, "jal");
        drive(1'b1, 5'd16, 5'd31, 5'd20, 1'b0, "lui");

        // Unassigned opcodes, random funct.
        for (int o = 17; o < 32; o++) begin
            rf = 5'($urandom_range(0, 31));
            drive(1'b1, 5'(o), rf, 5'd0, 1'b1, $sformatf("illegal_opc%0d", o));
        end

        // Back-to-back changes, then a one-edge reset pulse mid-stream.
        drive(1'b1, 5'd0, 5'd0, 5'd0,  1'b0, "b2b_rtype_add");
        drive(1'b1, 5'd1, 5'd4, 5'd20, 1'b0, "b2b_rext_passb");
        drive(1'b1, 5'd2, 5'd0, 5'd0,  1'b0, "b2b_addi");
        drive(1'b1, 5'd1, 5'd7, 5'd23, 1'b0, "b2b_rext_nor");
        drive(1'b0, 5'd1, 5'd4, 5'd0,  1'b0, "midstream_reset");
        drive(1'b1, 5'd1, 5'd4, 5'd20, 1'b0, "resume_after_reset");
        drive(1'b1, 5'd20, 5'd0, 5'd0, 1'b1, "illegal_after_resume");
        drive(1'b1, 5'd13, 5'd0, 5'd14, 1'b0, "legal_after_illegal");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: %0d entries pending, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
